wb_regfile: RTL and testbench
=============================

# wb_regfile

Writeback stage and integer register file for the 5-stage RV32I pipeline. It takes the writeback bundle from the MEM/WB pipeline register and selects the result (ALU, load data or link address). It commits that result to a 32×32 register file and serves the two decode-stage read ports, with same-cycle write-to-read bypass. It also keeps a retired-instruction counter.

## Interface
- XLEN, 32, data width of registers and result sources
- CNT_W, 64, width of retired-instruction counter
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- wb_valid_i  input  1  a real instruction (not a bubble or flush) occupies WB this cycle
- wb_alu_result_i  input  XLEN  ALU result from MEM/WB
- wb_mem_read_data_i  input  XLEN  load data from MEM/WB
- wb_pc_plus_4_i  input  XLEN  link address from MEM/WB
- wb_rd_addr_i  input  5  destination register
- wb_reg_write_en_i  input  1  RegWrite control
- wb_mem_to_reg_i  input  2  result select: 00 ALU, 01 MEM, 10 PC+4, 11 reserved
- id_rs1_addr_i  input  5  read port 1 address
- id_rs2_addr_i  input  5  read port 2 address
- id_rs1_data_o  output  XLEN  read port 1 data (combinational)
- id_rs2_data_o  output  XLEN  read port 2 data (combinational)
- wb_write_data_o  output  XLEN  selected writeback value, for EX forwarding
- wb_write_en_o  output  1  qualified write strobe, for EX forwarding
- instret_o  output  CNT_W  retired-instruction count
- sel_err_o  output  1  registered flag: a valid instruction retired with select 11

## Operation
- Result mux: 00 → alu_result; 01 → mem_read_data; 10 → pc_plus_4; 11 → 0.
- The mux output always drives wb_write_data_o.
- Qualified write: wb_write_en_o = wb_valid_i & wb_reg_write_en_i & (wb_rd_addr_i != 0) & (wb_mem_to_reg_i != 11).
- Storage: x1..x31 are registers. x0 is not stored and always reads 0. Writes to x0 are dropped.
- Read ports are combinational:
  - Address 0 → 0.
  - Otherwise, if wb_write_en_o is set and the address equals wb_rd_addr_i → wb_write_data_o (bypass).
  - Otherwise → stored value.
- Both ports may read the same register, including while it is being written. Both then return the bypassed value.
- instret increments by 1 on every cycle with wb_valid_i=1, whether or not the instruction writes (SW, BEQ and similar still count).
- instret wraps from all-ones to 0 with no flag.
- sel_err_o is set on a cycle with wb_valid_i=1 and select 11. It is sticky until reset.
- Bubbles (wb_valid_i=0) change nothing: no write, no count, and no sel_err, whatever the other inputs hold.

## Timing
- Reset (rst_n=0, takes effect immediately, asynchronous):
  - x1..x31 = 0, instret_o = 0, sel_err_o = 0.
  - Read outputs therefore return 0, provided there is no active bypass.
  - Writes are blocked while rst_n=0.
- Write latency: the register array updates on the rising edge where wb_write_en_o=1. The value is visible through the bypass in the same cycle, and from storage on the following cycles.
- Read latency: 0 cycles (combinational from address and WB inputs).
- instret_o and sel_err_o update on the rising edge and are visible one cycle after the retiring instruction.
- Reset deasserted mid-stream: the first edge after release may write and count normally.
- No stall input. The MEM/WB register upstream holds its outputs during stalls, and the pipeline drives wb_valid_i=0 for held or repeated instructions.

## Test plan
- Reset: rst_n=0 with read addresses 1 and 31 → both data outputs 0, instret_o=0, sel_err_o=0. Release rst_n and hold wb_valid_i=0 for 3 cycles → values unchanged.
- R-type, load and JAL writes:
  - valid, en=1, sel=00, rd=3, alu=0x0000000F → x3=0x0F.
  - sel=01, rd=5, mem=0x00000014 → x5=0x14.
  - sel=10, rd=1, pc4=0x0000002C → x1=0x2C.
  - Read back on both ports next cycle.
  - instret_o=3.
- Bypass: in the same cycle write rd=7 with 0xDEADBEEF and set rs1=rs2=7 → both read ports return 0xDEADBEEF that cycle. Next cycle (no write) → 0xDEADBEEF from storage.
- x0 and non-writes:
  - Write rd=0, alu=0xFFFFFFFF → rs1=0 reads 0 and wb_write_en_o=0.
  - Valid with en=0 (store) → no register change, instret increments.
  - wb_valid_i=0 with en=1, rd=9 → x9 unchanged, instret unchanged.
- Reserved select: valid, en=1, sel=11, rd=4 → x4 unchanged, wb_write_en_o=0. Next cycle sel_err_o=1 and it stays 1 until reset.
- Counter wrap and async reset:
  - Force instret to all-ones via a back-to-back valid stream (use CNT_W=4 in the bench) → it wraps to 0.
  - Assert rst_n between clock edges while a write to x3 is pending → x3 and instret clear immediately and the pending write is not committed.

Source files
------------

// File: rtl/wb_regfile.sv
`default_nettype none
// ============================================================================
// Module   : wb_regfile
// Brief    : RV32I writeback result select, 32x32 register file with
//            write-to-read bypass, and retired-instruction counter.
// Revision : 1.0 - initial release
// ============================================================================
module wb_regfile #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wb_valid_i,
   input  logic [XLEN-1:0]   wb_alu_result_i,
   input  logic [XLEN-1:0]   wb_mem_read_data_i,
   input  logic [XLEN-1:0]   wb_pc_plus_4_i,
   input  logic [4:0]        wb_rd_addr_i,
   input  logic              wb_reg_write_en_i,
   input  logic [1:0]        wb_mem_to_reg_i,
   input  logic [4:0]        id_rs1_addr_i,
   input  logic [4:0]        id_rs2_addr_i,
   output logic [XLEN-1:0]   id_rs1_data_o,
   output logic [XLEN-1:0]   id_rs2_data_o,
   output logic [XLEN-1:0]   wb_write_data_o,
   output logic              wb_write_en_o,
   output logic [CNT_W-1:0]  instret_o,
   output logic              sel_err_o
);

   localparam logic [1:0] c_SEL_ALU  = 2'b00;
   localparam logic [1:0] c_SEL_MEM  = 2'b01;
   localparam logic [1:0] c_SEL_PC4  = 2'b10;
   localparam logic [1:0] c_SEL_RSVD = 2'b11;

   // x0 is hardwired, so only x1..x31 get storage
   logic [XLEN-1:0]  r_regs [1:31];
   logic [CNT_W-1:0] r_instret;
   logic             r_sel_err;
   logic [XLEN-1:0]  w_write_data;
   logic             w_write_en;

   always_comb begin
      w_write_data = '0;
      case (wb_mem_to_reg_i)
         c_SEL_ALU: w_write_data = wb_alu_result_i;
         c_SEL_MEM: w_write_data = wb_mem_read_data_i;
         c_SEL_PC4: w_write_data = wb_pc_plus_4_i;
         default:   w_write_data = '0;
      endcase
   end

   assign w_write_en = wb_valid_i & wb_reg_write_en_i &
                       (wb_rd_addr_i != 5'd0) & (wb_mem_to_reg_i != c_SEL_RSVD);

   // Reads bypass the in-flight writeback so decode sees it in the same cycle
   always_comb begin
      id_rs1_data_o = '0;
      if (id_rs1_addr_i != 5'd0) begin
         if (w_write_en && (id_rs1_addr_i == wb_rd_addr_i))
            id_rs1_data_o = w_write_data;
         else
            id_rs1_data_o = r_regs[id_rs1_addr_i];
      end
   end

   always_comb begin
      id_rs2_data_o = '0;
      if (id_rs2_addr_i != 5'd0) begin
         if (w_write_en && (id_rs2_addr_i == wb_rd_addr_i))
            id_rs2_data_o = w_write_data;
         else
            id_rs2_data_o = r_regs[id_rs2_addr_i];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 1; i < 32; i++)
            r_regs[i] <= '0;
      end else if (w_write_en) begin
         r_regs[wb_rd_addr_i] <= w_write_data;
      end
   end

   // Counts every retiring instruction, writers or not; wraps silently
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_instret <= '0;
         r_sel_err <= 1'b0;
      end else if (wb_valid_i) begin
         r_instret <= r_instret + CNT_W'(1);
         if (wb_mem_to_reg_i == c_SEL_RSVD)
            r_sel_err <= 1'b1;
      end
   end

   assign wb_write_data_o = w_write_data;
   assign wb_write_en_o   = w_write_en;
   assign instret_o       = r_instret;
   assign sel_err_o       = r_sel_err;

endmodule
`default_nettype wire

// File: tb/tb_wb_regfile.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_regfile
// Brief    : Self-checking scoreboard bench for wb_regfile (CNT_W = 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_regfile;

   localparam int XLEN  = 32;
   localparam int CNT_W = 4;

   localparam int c_RS1 = 0;
   localparam int c_RS2 = 1;
   localparam int c_WD  = 2;
   localparam int c_WE  = 3;
   localparam int c_CNT = 4;
   localparam int c_ERR = 5;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             wb_valid;
   logic [XLEN-1:0]  wb_alu;
   logic [XLEN-1:0]  wb_mem;
   logic [XLEN-1:0]  wb_pc4;
   logic [4:0]       wb_rd;
   logic             wb_en;
   logic [1:0]       wb_sel;
   logic [4:0]       rs1_addr;
   logic [4:0]       rs2_addr;
   logic [XLEN-1:0]  rs1_data;
   logic [XLEN-1:0]  rs2_data;
   logic [XLEN-1:0]  wdata;
   logic             wen;
   logic [CNT_W-1:0] instret;
   logic             sel_err;

   wb_regfile #(.XLEN(XLEN), .CNT_W(CNT_W)) u_dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .wb_valid_i         (wb_valid),
      .wb_alu_result_i    (wb_alu),
      .wb_mem_read_data_i (wb_mem),
      .wb_pc_plus_4_i     (wb_pc4),
      .wb_rd_addr_i       (wb_rd),
      .wb_reg_write_en_i  (wb_en),
      .wb_mem_to_reg_i    (wb_sel),
      .id_rs1_addr_i      (rs1_addr),
      .id_rs2_addr_i      (rs2_addr),
      .id_rs1_data_o      (rs1_data),
      .id_rs2_data_o      (rs2_data),
      .wb_write_data_o    (wdata),
      .wb_write_en_o      (wen),
      .instret_o          (instret),
      .sel_err_o          (sel_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      int          sig;
      logic [63:0] exp;
   } exp_t;

   exp_t sb[$];

   int n_total = 0;
   int n_bad   = 0;

   // reference model state
   logic [XLEN-1:0]  m_regs [32];
   logic [CNT_W-1:0] m_instret;
   logic             m_selerr;
   logic [XLEN-1:0]  e_wd;
   logic             e_we;

   task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] observe(input int sig);
      case (sig)
         c_RS1:   return 64'(rs1_data);
         c_RS2:   return 64'(rs2_data);
         c_WD:    return 64'(wdata);
         c_WE:    return 64'(wen);
         c_CNT:   return 64'(instret);
         default: return 64'(sel_err);
      endcase
   endfunction

   task automatic expect_sig(input string tag, input int sig, input logic [63:0] val);
      exp_t e;
      e.tag = tag;
      e.sig = sig;
      e.exp = val;
      sb.push_back(e);
   endtask

   task automatic drain();
      exp_t e;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         check_value(e.tag, observe(e.sig), e.exp);
      end
   endtask

   function automatic logic [XLEN-1:0] model_read(input logic [4:0] a);
      if (a == 5'd0)                return '0;
      if (e_we && (a == wb_rd))     return e_wd;
      return m_regs[a];
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
      m_instret = '0;
      m_selerr  = 1'b0;
   endtask

   // Drive one WB cycle and queue the model's view of every output
   task automatic drive(input logic v, input logic en, input logic [1:0] sel,
                        input logic [4:0] rd, input logic [XLEN-1:0] alu,
                        input logic [XLEN-1:0] mem, input logic [XLEN-1:0] pc4,
                        input logic [4:0] r1, input logic [4:0] r2, input string tag);
      wb_valid = v;  wb_en  = en;  wb_sel = sel; wb_rd = rd;
      wb_alu   = alu; wb_mem = mem; wb_pc4 = pc4;
      rs1_addr = r1; rs2_addr = r2;
      case (sel)
         2'b00:   e_wd = alu;
         2'b01:   e_wd = mem;
         2'b10:   e_wd = pc4;
         default: e_wd = '0;
      endcase
      e_we = v && en && (rd != 5'd0) && (sel != 2'b11);
      expect_sig({tag, ".rs1"}, c_RS1, 64'(model_read(r1)));
      expect_sig({tag, ".rs2"}, c_RS2, 64'(model_read(r2)));
      expect_sig({tag, ".wd"},  c_WD,  64'(e_wd));
      expect_sig({tag, ".we"},  c_WE,  64'(e_we));
      expect_sig({tag, ".cnt"}, c_CNT, 64'(m_instret));
      expect_sig({tag, ".err"}, c_ERR, 64'(m_selerr));
   endtask

   task automatic idle(input logic [4:0] r1, input logic [4:0] r2, input string tag);
      drive(1'b0, 1'b0, 2'b00, 5'd0, '0, '0, '0, r1, r2, tag);
   endtask

   task automatic finish_cycle();
      @(negedge clk);
      drain();
      @(posedge clk);
      if (e_we)                        m_regs[wb_rd] = e_wd;
      if (wb_valid)                    m_instret = m_instret + 1'b1;
      if (wb_valid && wb_sel == 2'b11) m_selerr = 1'b1;
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      model_reset();
      rst_n = 1'b0;
      e_we  = 1'b0;
      e_wd  = '0;
      idle(5'd1, 5'd31, "rst");
      #2;
      drain();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         idle(5'd1, 5'd31, "rst_hold");
         expect_sig("rst_hold.cnt0", c_CNT, 64'd0);
         finish_cycle();
      end

      drive(1, 1, 2'b00, 5'd3, 32'h0000_000F, 32'h0, 32'h0, 5'd3, 5'd3, "wr_alu");
      finish_cycle();
      drive(1, 1, 2'b01, 5'd5, 32'h0, 32'h0000_0014, 32'h0, 5'd5, 5'd3, "wr_mem");
      finish_cycle();
      drive(1, 1, 2'b10, 5'd1, 32'h0, 32'h0, 32'h0000_002C, 5'd1, 5'd5, "wr_jal");
      finish_cycle();
      idle(5'd3, 5'd5, "rd35");
      expect_sig("rd35.x3", c_RS1, 64'h0F);
      expect_sig("rd35.x5", c_RS2, 64'h14);
      expect_sig("rd35.cnt3", c_CNT, 64'd3);
      finish_cycle();
      idle(5'd1, 5'd1, "rd1");
      expect_sig("rd1.x1a", c_RS1, 64'h2C);
      expect_sig("rd1.x1b", c_RS2, 64'h2C);
      finish_cycle();

      drive(1, 1, 2'b00, 5'd7, 32'hDEAD_BEEF, 32'h0, 32'h0, 5'd7, 5'd7, "byp");
      expect_sig("byp.rs1c", c_RS1, 64'hDEAD_BEEF);
      expect_sig("byp.rs2c", c_RS2, 64'hDEAD_BEEF);
      finish_cycle();
      idle(5'd7, 5'd7, "byp_st");
      expect_sig("byp_st.rs1c", c_RS1, 64'hDEAD_BEEF);
      finish_cycle();

      drive(1, 1, 2'b00, 5'd0, 32'hFFFF_FFFF, 32'h0, 32'h0, 5'd0, 5'd0, "x0");
      expect_sig("x0.rd0", c_RS1, 64'd0);
      expect_sig("x0.we0", c_WE, 64'd0);
      finish_cycle();
      drive(1, 0, 2'b00, 5'd3, 32'h55, 32'h0, 32'h0, 5'd3, 5'd5, "store");
      expect_sig("store.x3", c_RS1, 64'h0F);
      finish_cycle();
      drive(0, 1, 2'b00, 5'd9, 32'h99, 32'h0, 32'h0, 5'd9, 5'd9, "bubble");
      expect_sig("bubble.cnt6", c_CNT, 64'd6);
      expect_sig("bubble.we0", c_WE, 64'd0);
      finish_cycle();
      idle(5'd9, 5'd3, "bubble_after");
      expect_sig("bubble_after.x9", c_RS1, 64'd0);
      expect_sig("bubble_after.x3", c_RS2, 64'h0F);
      expect_sig("bubble_after.cnt6", c_CNT, 64'd6);
      finish_cycle();

      drive(1, 1, 2'b11, 5'd4, 32'h44, 32'h45, 32'h46, 5'd4, 5'd4, "rsv");
      expect_sig("rsv.we0", c_WE, 64'd0);
      expect_sig("rsv.err0", c_ERR, 64'd0);
      finish_cycle();
      idle(5'd4, 5'd4, "rsv_after");
      expect_sig("rsv_after.x4", c_RS1, 64'd0);
      expect_sig("rsv_after.err1", c_ERR, 64'd1);
      expect_sig("rsv_after.cnt7", c_CNT, 64'd7);
      finish_cycle();
      drive(0, 1, 2'b11, 5'd4, 32'h44, 32'h0, 32'h0, 5'd4, 5'd1, "rsv_bubble");
      finish_cycle();

      for (int i = 0; i < 20 && m_instret != 4'hF; i++) begin
         drive(1, 0, 2'b00, 5'd0, 32'h0, 32'h0, 32'h0, 5'd1, 5'd3, "wrap");
         finish_cycle();
      end
      drive(1, 0, 2'b00, 5'd0, 32'h0, 32'h0, 32'h0, 5'd1, 5'd3, "wrap_last");
      expect_sig("wrap_last.cntF", c_CNT, 64'hF);
      finish_cycle();
      idle(5'd1, 5'd3, "wrap0");
      expect_sig("wrap0.cnt0", c_CNT, 64'd0);
      expect_sig("wrap0.err_sticky", c_ERR, 64'd1);
      finish_cycle();

      drive(1, 1, 2'b00, 5'd3, 32'h33, 32'h0, 32'h0, 5'd3, 5'd3, "x3w");
      finish_cycle();
      drive(1, 1, 2'b00, 5'd3, 32'hAB, 32'h0, 32'h0, 5'd3, 5'd7, "pend");
      @(negedge clk);
      drain();
      #2;
      rst_n    = 1'b0;
      wb_valid = 1'b0;
      model_reset();
      #1;
      expect_sig("arst.x3", c_RS1, 64'd0);
      expect_sig("arst.x7", c_RS2, 64'd0);
      expect_sig("arst.cnt", c_CNT, 64'd0);
      expect_sig("arst.err", c_ERR, 64'd0);
      drain();
      wb_valid = 1'b1;
      @(posedge clk);
      #1;
      wb_valid = 1'b0;
      rst_n    = 1'b1;
      #1;
      expect_sig("arst_edge.x3", c_RS1, 64'd0);
      expect_sig("arst_edge.cnt", c_CNT, 64'd0);
      drain();
      drive(1, 1, 2'b00, 5'd3, 32'h77, 32'h0, 32'h0, 5'd1, 5'd5, "post_wr");
      finish_cycle();
      idle(5'd3, 5'd5, "post_rd");
      expect_sig("post_rd.x3", c_RS1, 64'h77);
      expect_sig("post_rd.x5", c_RS2, 64'd0);
      expect_sig("post_rd.cnt1", c_CNT, 64'd1);
      finish_cycle();

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
